// File: rtl/non_data_fifo_arbiter.sv
// Non-data FIFO arbiter: grants one of two requesters round-robin and copies
// that requester's packet byte by byte into a downstream FIFO. It keeps its
// own count of FIFO occupancy so that a packet is granted only when it fits.
//
// Handshake: a requester holds reqI with lenI/dataI stable. The arbiter
// pulses ackI in every cycle in which the current byte is written. The
// requester then presents the next byte before the following edge. doneI
// marks the last byte, and errI rejects an illegal length. The requester
// drops reqI in the cycle after doneI or errI.
// The FSM state is visible through busy (high in XFER).
module non_data_fifo_arbiter #(
    parameter int DEPTH  = 200,
    parameter int MAXLEN = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       req0,
    input  logic       req1,
    input  logic [3:0] len0,
    input  logic [3:0] len1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic       ack0,
    output logic       ack1,
    output logic       done0,
    output logic       done1,
    output logic       err0,
    output logic       err1,
    output logic       fifo_w_enable,
    output logic [7:0] fifo_w_data,
    input  logic       fifo_r_enable,
    input  logic       fifo_full,
    output logic       busy,
    output logic [7:0] occupancy
);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    localparam logic [8:0] DEPTH_W  = 9'(DEPTH);
    localparam logic [4:0] MAXLEN_W = 5'(MAXLEN);

    state_t     state_q, state_d;
    logic       id_q, id_d;        // granted requester
    logic [3:0] rem_q, rem_d;      // bytes still to write
    logic       ptr_q, ptr_d;      // 0: favour req0, 1: favour req1
    logic [7:0] occ_q, occ_d;
    logic       err0_q, err0_d;
    logic       err1_q, err1_d;
    logic       wr;

    logic       legal0, legal1, elig0, elig1, rd_cnt;
    logic [8:0] free_bytes;

    assign legal0     = (len0 != 4'd0) && ({1'b0, len0} <= MAXLEN_W);
    assign legal1     = (len1 != 4'd0) && ({1'b0, len1} <= MAXLEN_W);
    assign free_bytes = DEPTH_W - {1'b0, occ_q};
    assign elig0      = req0 && legal0 && (free_bytes >= {5'd0, len0});
    assign elig1      = req1 && legal1 && (free_bytes >= {5'd0, len1});
    // A read on an empty FIFO is not counted.
    assign rd_cnt     = fifo_r_enable && (occ_q != 8'd0);

    // State register and tracked occupancy; reset aborts any packet in flight.
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            state_q <= IDLE;
            id_q    <= 1'b0;
            rem_q   <= 4'd0;
            ptr_q   <= 1'b0;
            occ_q   <= 8'd0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            rem_q   <= rem_d;
            ptr_q   <= ptr_d;
            occ_q   <= occ_d;
            err0_q  <= err0_d;
            err1_q  <= err1_d;
        end
    end

    // Arbitration, length rejection, byte transfer and occupancy next state.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        rem_d   = rem_q;
        ptr_d   = ptr_q;
        occ_d   = occ_q;
        err0_d  = 1'b0;
        err1_d  = 1'b0;
        wr      = 1'b0;

        case (state_q)
            IDLE: begin
                // One rejection per cycle keeps err0/err1 exclusive. A requester
                // whose err is showing is still holding req and must not re-fire.
                if (req0 && !legal0 && !err0_q) begin
                    err0_d = 1'b1;
                end else if (req1 && !legal1 && !err1_q) begin
                    err1_d = 1'b1;
                end

                if (elig0 && (!elig1 || !ptr_q)) begin
                    state_d = XFER;
                    id_d    = 1'b0;
                    rem_d   = len0;
                end else if (elig1) begin
                    state_d = XFER;
                    id_d    = 1'b1;
                    rem_d   = len1;
                end
            end
            XFER: begin
                if (!fifo_full) begin
                    wr    = 1'b1;
                    rem_d = rem_q - 4'd1;
                    if (rem_q == 4'd1) begin
                        state_d = IDLE;
                        ptr_d   = ~id_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (wr && !rd_cnt) begin
            if ({1'b0, occ_q} < DEPTH_W) begin
                occ_d = occ_q + 8'd1;
            end
        end else if (rd_cnt && !wr) begin
            occ_d = occ_q - 8'd1;
        end
    end

    assign fifo_w_enable = wr;
    assign fifo_w_data   = wr ? (id_q ? data1 : data0) : 8'h00;
    assign ack0          = wr && !id_q;
    assign ack1          = wr && id_q;
    assign done0         = wr && !id_q && (rem_q == 4'd1);
    assign done1         = wr && id_q && (rem_q == 4'd1);
    assign err0          = err0_q;
    assign err1          = err1_q;
    assign busy          = (state_q == XFER);
    assign occupancy     = occ_q;

endmodule

// File: tb/tb_non_data_fifo_arbiter.sv
// Directed bench for non_data_fifo_arbiter. Expected FIFO bytes {id, byte}
// are queued when a packet is issued, and a monitor pops them on each write.
module tb_non_data_fifo_arbiter;

  logic       clk = 1'b0;
  logic       n_rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [3:0] len0 = 4'd0, len1 = 4'd0;
  logic [7:0] data0 = 8'h00, data1 = 8'h00;
  logic       fifo_r_enable = 1'b0, fifo_full = 1'b0;
  logic       ack0, ack1, done0, done1, err0, err1;
  logic       fifo_w_enable, busy;
  logic [7:0] fifo_w_data, occupancy;

  logic [8:0] exp_q[$];
  int n_chk = 0, n_fail = 0;
  int wr_cnt = 0, err0_cnt = 0, err1_cnt = 0, w0;
  int go0 = 0, go1 = 0, seen0 = 0, seen1 = 0;
  int idx0 = 0, idx1 = 0;
  logic [3:0] st_len0, st_len1;
  logic [7:0] st_base0, st_base1;
  logic [7:0] pkt0[16], pkt1[16];

  non_data_fifo_arbiter #(.DEPTH(200), .MAXLEN(8)) dut (
    .clk(clk), .n_rst(n_rst),
    .req0(req0), .req1(req1), .len0(len0), .len1(len1),
    .data0(data0), .data1(data1),
    .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
    .err0(err0), .err1(err1),
    .fifo_w_enable(fifo_w_enable), .fifo_w_data(fifo_w_data),
    .fifo_r_enable(fifo_r_enable), .fifo_full(fifo_full),
    .busy(busy), .occupancy(occupancy)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // requester models: advance on ack, drop req after done/err, start staged packets
  task automatic driver();
    forever begin
      @(negedge clk);
      #1;
      if (n_rst) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end else begin
        if (ack0) begin idx0++; data0 = pkt0[idx0]; end
        if (ack1) begin idx1++; data1 = pkt1[idx1]; end
        if (done0 || err0) req0 = 1'b0;
        if (done1 || err1) req1 = 1'b0;
        if (go0 != seen0) begin
          seen0 = go0;
          for (int k = 0; k < 16; k++) pkt0[k] = st_base0 + 8'(k);
          idx0 = 0; data0 = pkt0[0]; len0 = st_len0; req0 = 1'b1;
        end
        if (go1 != seen1) begin
          seen1 = go1;
          for (int k = 0; k < 16; k++) pkt1[k] = st_base1 + 8'(k);
          idx1 = 0; data1 = pkt1[0]; len1 = st_len1; req1 = 1'b1;
        end
      end
    end
  endtask

  // scoreboard monitor
  task automatic monitor();
    logic [8:0] e;
    forever begin
      @(negedge clk);
      check("ack_excl", 32'(ack0 & ack1), 0);
      check("ack_vs_wen", 32'(ack0 | ack1), 32'(fifo_w_enable));
      check("done_excl", 32'(done0 & done1), 0);
      check("err_excl", 32'(err0 & err1), 0);
      if (err0) err0_cnt++;
      if (err1) err1_cnt++;
      if (fifo_w_enable) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_write: got data %0h, expected no write", fifo_w_data);
        end else begin
          e = exp_q.pop_front();
          check("wr_data", 32'(fifo_w_data), 32'(e[7:0]));
          check("wr_id", 32'(ack1), 32'(e[8]));
        end
      end
    end
  endtask

  task automatic load(input int id, input logic [3:0] n, input logic [7:0] base);
    if (id == 0) begin st_len0 = n; st_base0 = base; go0++; end
    else begin st_len1 = n; st_base1 = base; go1++; end
  endtask

  task automatic expect_pkt(input int id, input int n, input logic [7:0] base);
    logic [31:0] idv;
    idv = id;
    for (int k = 0; k < n; k++) exp_q.push_back({idv[0], base + 8'(k)});
  endtask

  task automatic wait_quiet(input string name, input int budget);
    int cyc;
    bit ok;
    cyc = 0;
    ok = 1'b0;
    while (!ok && cyc < budget) begin
      @(negedge clk);
      cyc++;
      ok = !busy && !req0 && !req1 && (go0 == seen0) && (go1 == seen1);
    end
    check(name, 32'(ok), 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    n_rst = 1'b0;
  endtask

  initial begin
    fork
      driver();
      monitor();
    join_none

    // reset state
    repeat (2) @(negedge clk);
    check("rst_outputs", 32'({ack0, ack1, done0, done1, err0, err1, fifo_w_enable, busy}), 0);
    check("rst_wdata", 32'(fifo_w_data), 0);
    check("rst_occ", 32'(occupancy), 0);
    n_rst = 1'b0;

    // single 3-byte packet: grant cycle, then A1 A2 A3, done on the third
    load(0, 4'd3, 8'hA1);
    expect_pkt(0, 3, 8'hA1);
    #2;
    check("t1_grant_no_write", 32'(fifo_w_enable), 0);
    check("t1_grant_idle", 32'(busy), 0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("t1_wen", 32'(fifo_w_enable), 1);
      check("t1_done0", 32'(done0), 32'(k == 3));
    end
    wait_quiet("t1_quiet", 10);
    check("t1_occ", 32'(occupancy), 3);

    // both requesting twice: order 0,1,0,1 without interleaving
    do_reset();
    load(0, 4'd2, 8'hB0);
    load(1, 4'd2, 8'hC0);
    expect_pkt(0, 2, 8'hB0);
    expect_pkt(1, 2, 8'hC0);
    wait_quiet("t2_quiet_a", 20);
    load(0, 4'd2, 8'hD0);
    load(1, 4'd2, 8'hE0);
    expect_pkt(0, 2, 8'hD0);
    expect_pkt(1, 2, 8'hE0);
    wait_quiet("t2_quiet_b", 20);
    check("t2_occ", 32'(occupancy), 8);

    // fill to 195, then a 6-byte request only fits after one read
    do_reset();
    for (int k = 0; k < 24; k++) begin
      load(0, 4'd8, 8'(k * 8));
      expect_pkt(0, 8, 8'(k * 8));
      wait_quiet("t3_fill", 20);
    end
    load(0, 4'd3, 8'hF0);
    expect_pkt(0, 3, 8'hF0);
    wait_quiet("t3_fill_last", 20);
    check("t3_occ195", 32'(occupancy), 195);
    load(1, 4'd6, 8'h30);
    expect_pkt(1, 6, 8'h30);
    repeat (4) @(negedge clk);
    check("t3_blocked_busy", 32'(busy), 0);
    check("t3_blocked_occ", 32'(occupancy), 195);
    fifo_r_enable = 1'b1;
    @(negedge clk);
    fifo_r_enable = 1'b0;
    wait_quiet("t3_quiet", 20);
    check("t3_occ200", 32'(occupancy), 200);

    // illegal lengths with a full tracked FIFO
    err0_cnt = 0;
    err1_cnt = 0;
    w0 = wr_cnt;
    load(0, 4'd0, 8'h00);
    wait_quiet("t4_quiet_a", 10);
    check("t4_err0_first", 32'(err0_cnt), 1);
    check("t4_err1_not_yet", 32'(err1_cnt), 0);
    load(1, 4'd9, 8'h00);
    wait_quiet("t4_quiet_b", 10);
    check("t4_err0_once", 32'(err0_cnt), 1);
    check("t4_err1_once", 32'(err1_cnt), 1);
    check("t4_no_writes", 32'(wr_cnt - w0), 0);
    check("t4_occ", 32'(occupancy), 200);

    // FIFO full for two cycles mid-packet
    do_reset();
    w0 = wr_cnt;
    load(0, 4'd5, 8'h50);
    expect_pkt(0, 5, 8'h50);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 fifo_full = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("t5_full_wen", 32'(fifo_w_enable), 0);
      check("t5_full_ack", 32'(ack0), 0);
    end
    @(posedge clk);
    #1 fifo_full = 1'b0;
    wait_quiet("t5_quiet", 20);
    check("t5_wr_count", 32'(wr_cnt - w0), 5);
    check("t5_occ", 32'(occupancy), 5);

    // reset after the 2nd byte of a 5-byte packet; req0 regains priority
    do_reset();
    load(0, 4'd1, 8'h11);
    expect_pkt(0, 1, 8'h11);
    wait_quiet("t6_pre", 10);
    load(1, 4'd5, 8'h70);
    expect_pkt(1, 2, 8'h70);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 n_rst = 1'b1;
    #1;
    check("t6_rst_outputs", 32'({ack0, ack1, done0, done1, err0, err1, fifo_w_enable, busy}), 0);
    check("t6_rst_wdata", 32'(fifo_w_data), 0);
    check("t6_rst_occ", 32'(occupancy), 0);
    repeat (2) @(negedge clk);
    n_rst = 1'b0;
    load(0, 4'd1, 8'h90);
    load(1, 4'd1, 8'hA0);
    expect_pkt(0, 1, 8'h90);
    expect_pkt(1, 1, 8'hA0);
    wait_quiet("t6_quiet", 20);
    check("t6_occ", 32'(occupancy), 2);

    check("queue_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
